// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between fetch_unit (master) and instruction memory (slave).
// One request is outstanding at a time; imemAddr stays stable until imemAck.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/FETCH/EXEC sequencing over the imem handshake,
// next-PC selection (PC+4 / branch / jump / jr) and the retired-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic [1:0]   pcSrc,
  input  logic [31:0]  jrAddr,
  input  logic         execHold,
  output logic [31:0]  instr,
  output logic [5:0]   opCode,
  output logic [5:0]   func,
  output logic [31:0]  pcPlus4,
  output logic         instrValid,
  output logic         pcMisalign,
  output logic [31:0]  instrCount
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] count_r;
  logic        misalign_r;
  logic        commit_s;
  logic        jr_misalign_s;
  logic [31:0] next_pc_s;

  // Next PC; branch offset is relative to PC+4, jump keeps the PC+4 region bits.
  function automatic logic [31:0] calc_next_pc(
    input logic [1:0]  src,
    input logic [31:0] pc,
    input logic [31:0] ir,
    input logic [31:0] jr
  );
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    case (src)
      2'd0:    calc_next_pc = pc4;
      2'd1:    calc_next_pc = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
      2'd2:    calc_next_pc = {pc4[31:28], ir[25:0], 2'b00};
      2'd3:    calc_next_pc = {jr[31:2], 2'b00};
      default: calc_next_pc = pc4;
    endcase
  endfunction

  // Commit qualification and next-PC selection for the current execute window.
  always_comb begin
    commit_s      = 1'b0;
    jr_misalign_s = 1'b0;
    next_pc_s     = calc_next_pc(pcSrc, pc_r, instr_r, jrAddr);
    if (state_r == ST_EXEC) begin
      commit_s = ~execHold;
    end else begin
      commit_s = 1'b0;
    end
    if (commit_s && (pcSrc == 2'd3) && (jrAddr[1:0] != 2'b00)) begin
      jr_misalign_s = 1'b1;
    end else begin
      jr_misalign_s = 1'b0;
    end
  end

  // Fetch sequencer; an unused encoding falls back to BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      case (state_r)
        ST_BOOT:  state_r <= ST_FETCH;
        ST_FETCH: state_r <= imem.imemAck ? ST_EXEC : ST_FETCH;
        ST_EXEC:  state_r <= commit_s ? ST_FETCH : ST_EXEC;
        default:  state_r <= ST_BOOT;
      endcase
    end
  end

  // Instruction register captures only on an ack seen while fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 32'h0000_0000;
    end else if ((state_r == ST_FETCH) && imem.imemAck) begin
      instr_r <= imem.imemData;
    end else begin
      instr_r <= instr_r;
    end
  end

  // PC and retire counter advance together at the end of each execute window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      count_r <= 32'h0000_0000;
    end else if (commit_s) begin
      pc_r    <= next_pc_s;
      count_r <= count_r + 32'd1;
    end else begin
      pc_r    <= pc_r;
      count_r <= count_r;
    end
  end

  // Sticky misaligned-jr flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (jr_misalign_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign imem.imemReq  = (state_r == ST_FETCH);
  assign imem.imemAddr = pc_r;
  assign instrValid    = (state_r == ST_EXEC);
  assign instr         = instr_r;
  assign opCode        = instr_r[31:26];
  assign func          = instr_r[5:0];
  assign pcPlus4       = pc_r + 32'd4;
  assign pcMisalign    = misalign_r;
  assign instrCount    = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver plays instruction memory and controller from a
// directed table; a negedge monitor checks each fetch request and each execute window.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pcSrc;
  logic [31:0] jrAddr;
  logic        execHold;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [5:0]  func;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        pcMisalign;
  logic [31:0] instrCount;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .pcSrc      (pcSrc),
    .jrAddr     (jrAddr),
    .execHold   (execHold),
    .instr      (instr),
    .opCode     (opCode),
    .func       (func),
    .pcPlus4    (pcPlus4),
    .instrValid (instrValid),
    .pcMisalign (pcMisalign),
    .instrCount (instrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] count;
    logic        mis;
    int          period;
  } fetch_exp_t;

  typedef struct {
    logic [31:0] ir;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] pc4;
  } exec_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] pc4;
    int          lat;
    int          hold;
    logic [1:0]  src;
    logic [31:0] jr;
    logic [31:0] nxt;
    logic        mis;
  } vec_t;

  fetch_exp_t fetch_q[$];
  exec_exp_t  exec_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] cnt_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on the first cycle of each request and of each execute window.
  logic req_prev, valid_prev;
  int   period_cnt;
  always @(negedge clk) begin
    fetch_exp_t fe;
    exec_exp_t  ee;
    if (!rst_n) begin
      req_prev   <= 1'b0;
      valid_prev <= 1'b0;
      period_cnt <= 0;
    end else begin
      req_prev   <= bus.imemReq;
      valid_prev <= instrValid;
      period_cnt <= period_cnt + 1;
      if (bus.imemReq && !req_prev) begin
        if (fetch_q.size() == 0) begin
          check("fetch_unexpected", 32'd1, 32'd0);
        end else begin
          fe = fetch_q.pop_front();
          check("fetch_addr", bus.imemAddr, fe.addr);
          check("fetch_count", instrCount, fe.count);
          check("fetch_misalign", {31'd0, pcMisalign}, {31'd0, fe.mis});
          check("fetch_valid_low", {31'd0, instrValid}, 32'd0);
          if (fe.period != 0) check("period", period_cnt, fe.period);
        end
        period_cnt <= 1;
      end
      if (instrValid && !valid_prev) begin
        if (exec_q.size() == 0) begin
          check("exec_unexpected", 32'd1, 32'd0);
        end else begin
          ee = exec_q.pop_front();
          check("exec_instr", instr, ee.ir);
          check("exec_opcode", {26'd0, opCode}, {26'd0, ee.op});
          check("exec_func", {26'd0, func}, {26'd0, ee.fn});
          check("exec_pcplus4", pcPlus4, ee.pc4);
          check("exec_req_low", {31'd0, bus.imemReq}, 32'd0);
        end
      end
    end
  end

  task automatic wait_req();
    int w;
    w = 0;
    while (!bus.imemReq && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.imemReq) check("req_timeout", 32'd0, 32'd1);
  endtask

  // One instruction: fetch with ack latency, optional hold with junk pcSrc, then commit.
  task automatic run_vec(input vec_t v);
    fetch_exp_t fe;
    exec_exp_t  ee;
    ee.ir = v.data; ee.op = v.op; ee.fn = v.fn; ee.pc4 = v.pc4;
    exec_q.push_back(ee);
    wait_req();
    repeat (v.lat) begin
      @(posedge clk); #1;
      check("addr_stable", bus.imemAddr, v.pc);
    end
    bus.imemAck  = 1'b1;
    bus.imemData = v.data;
    @(posedge clk); #1;
    bus.imemAck  = 1'b0;
    bus.imemData = 32'hDEAD_BEEF;
    for (int h = 0; h < v.hold; h++) begin
      execHold = 1'b1;
      pcSrc    = 2'(h + 1);
      jrAddr   = 32'h1234_5677;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, instrValid}, 32'd1);
      check("hold_pc", bus.imemAddr, v.pc);
      check("hold_count", instrCount, cnt_model);
    end
    execHold = 1'b0;
    pcSrc    = v.src;
    jrAddr   = v.jr;
    cnt_model = cnt_model + 32'd1;
    fe.addr = v.nxt; fe.count = cnt_model; fe.mis = v.mis; fe.period = v.lat + 2 + v.hold;
    fetch_q.push_back(fe);
    @(posedge clk); #1;
    pcSrc  = 2'(v.src + 2'd1);
    jrAddr = 32'h0000_0003;
  endtask

  vec_t vt[11];

  initial begin
    fetch_exp_t fe;
    //        pc            data          op     fn     pc4           lat hold src  jr            nxt           mis
    vt[0]  = '{32'h0,       32'h2008_0005, 6'h08, 6'h05, 32'h4,       0, 0, 2'd0, 32'h0,        32'h4,        1'b0};
    vt[1]  = '{32'h4,       32'h0000_0020, 6'h00, 6'h20, 32'h8,       3, 0, 2'd0, 32'h0,        32'h8,        1'b0};
    vt[2]  = '{32'h8,       32'h0800_0004, 6'h02, 6'h04, 32'hC,       1, 0, 2'd2, 32'h0,        32'h10,       1'b0};
    vt[3]  = '{32'h10,      32'h1000_FFFF, 6'h04, 6'h3F, 32'h14,      0, 0, 2'd1, 32'h0,        32'h10,       1'b0};
    vt[4]  = '{32'h10,      32'h03E0_0008, 6'h00, 6'h08, 32'h14,      0, 0, 2'd3, 32'hF000_0000, 32'hF000_0000, 1'b0};
    vt[5]  = '{32'hF000_0000, 32'h0800_0040, 6'h02, 6'h00, 32'hF000_0004, 2, 0, 2'd2, 32'h0,     32'hF000_0100, 1'b0};
    vt[6]  = '{32'hF000_0100, 32'h03E0_0008, 6'h00, 6'h08, 32'hF000_0104, 0, 0, 2'd3, 32'h1002,  32'h1000,     1'b1};
    vt[7]  = '{32'h1000,    32'h03E0_0008, 6'h00, 6'h08, 32'h1004,    0, 0, 2'd3, 32'h2000,     32'h2000,     1'b1};
    vt[8]  = '{32'h2000,    32'h0000_0000, 6'h00, 6'h00, 32'h2004,    0, 3, 2'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vt[9]  = '{32'hFFFF_FFFC, 32'h8C00_0000, 6'h23, 6'h00, 32'h0,     1, 2, 2'd0, 32'h0,        32'h0,        1'b1};
    vt[10] = '{32'h0,       32'h2008_0005, 6'h08, 6'h05, 32'h4,       0, 0, 2'd0, 32'h0,        32'h4,        1'b0};

    rst_n = 1'b0; pcSrc = 2'd0; jrAddr = 32'h0; execHold = 1'b0;
    bus.imemAck = 1'b0; bus.imemData = 32'h0;
    cnt_model = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, bus.imemReq}, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_count", instrCount, 32'd0);
    check("rst_addr", bus.imemAddr, 32'd0);
    fe.addr = 32'h0; fe.count = 32'd0; fe.mis = 1'b0; fe.period = 0;
    fetch_q.push_back(fe);
    rst_n = 1'b1;
    #1 check("boot_req_low", {31'd0, bus.imemReq}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Reset while the fetch at address 0 is waiting for its ack.
    wait_req();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("midfetch_req_drop", {31'd0, bus.imemReq}, 32'd0);
    bus.imemAck  = 1'b1;
    bus.imemData = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_instr", instr, 32'd0);
    check("midrst_count", instrCount, 32'd0);
    check("midrst_misalign", {31'd0, pcMisalign}, 32'd0);
    check("midrst_valid", {31'd0, instrValid}, 32'd0);
    bus.imemAck = 1'b0;
    cnt_model = 32'd0;
    fe.addr = 32'h0; fe.count = 32'd0; fe.mis = 1'b0; fe.period = 0;
    fetch_q.push_back(fe);
    rst_n = 1'b1;
    #1 check("reboot_req_low", {31'd0, bus.imemReq}, 32'd0);

    run_vec(vt[10]);
    for (int w = 0; w < 10 && (fetch_q.size() != 0 || exec_q.size() != 0); w++) @(posedge clk);
    #1;
    check("fetch_q_drained", fetch_q.size(), 32'd0);
    check("exec_q_drained", exec_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
